// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue/hazard controller.
// The scoreboard entry records one in-flight multiply per pipeline stage.
package mul_pkg;

   localparam int unsigned MUL_STAGES_DEF = 5;
   localparam int unsigned REG_ADDR_W_DEF = 5;

   // The rd field is sized by REG_ADDR_W_DEF, so REG_ADDR_W on the top must match it.
   typedef struct packed {
      logic                      valid;
      logic                      we;
      logic [REG_ADDR_W_DEF-1:0] rd;
   } mul_sb_entry_t;

endpackage

// File: rtl/mul_hazard_cmp.sv
// Compares one scoreboard entry against the decode operands.
// Reports RAW (enabled source hits rd) and WAW (decode rd hits rd) for active entries only.
module mul_hazard_cmp
   import mul_pkg::*;
(
   input  mul_sb_entry_t             entry_i,
   input  logic [REG_ADDR_W_DEF-1:0] rs1_i,
   input  logic [REG_ADDR_W_DEF-1:0] rs2_i,
   input  logic                      rs1_used_i,
   input  logic                      rs2_used_i,
   input  logic [REG_ADDR_W_DEF-1:0] rd_i,
   input  logic                      we_i,
   output logic                      raw_o,
   output logic                      waw_o
);

   logic active;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      // x0 is hardwired, so an entry targeting it never blocks anything.
      active  = entry_i.valid & entry_i.we & (entry_i.rd != '0);
      rs1_hit = rs1_used_i & (rs1_i == entry_i.rd);
      rs2_hit = rs2_used_i & (rs2_i == entry_i.rd);
      raw_o   = active & (rs1_hit | rs2_hit);
      waw_o   = active & we_i & (rd_i != '0) & (rd_i == entry_i.rd);
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/hazard controller for the multi-cycle multiplier pipeline.
// Tracks in-flight multiplies per stage and gates decode issue into mult1 or the ALU.
module mul_issue_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned MUL_STAGES = MUL_STAGES_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             dec_mul_valid_i,
   input  logic                             dec_alu_valid_i,
   input  logic [REG_ADDR_W-1:0]            dec_rd_i,
   input  logic                             dec_we_i,
   input  logic [REG_ADDR_W-1:0]            dec_rs1_i,
   input  logic [REG_ADDR_W-1:0]            dec_rs2_i,
   input  logic                             dec_rs1_used_i,
   input  logic                             dec_rs2_used_i,
   input  logic                             flush_i,
   output logic                             stall_o,
   output logic                             mul_issue_o,
   output logic                             alu_issue_o,
   output logic [MUL_STAGES-1:0]            mul_stage_valid_o,
   output logic                             mul_wb_valid_o,
   output logic [REG_ADDR_W-1:0]            mul_wb_addr_o,
   output logic [$clog2(MUL_STAGES+1)-1:0]  inflight_cnt_o
);

   localparam int unsigned CntW = $clog2(MUL_STAGES + 1);

   mul_sb_entry_t [MUL_STAGES-1:0] sb_q;
   mul_sb_entry_t [MUL_STAGES-1:0] sb_d;
   logic [CntW-1:0]                cnt_q;
   logic [CntW-1:0]                cnt_d;

   logic [MUL_STAGES-2:0] raw_hit;
   logic [MUL_STAGES-2:0] waw_hit;
   logic                  wb_collision;
   logic                  hazard;

   // The last stage is excluded: the register file writes before it reads.
   for (genvar k = 0; k < MUL_STAGES - 1; k++) begin : g_cmp
      mul_hazard_cmp u_cmp (
         .entry_i    (sb_q[k]),
         .rs1_i      (dec_rs1_i),
         .rs2_i      (dec_rs2_i),
         .rs1_used_i (dec_rs1_used_i),
         .rs2_used_i (dec_rs2_used_i),
         .rd_i       (dec_rd_i),
         .we_i       (dec_we_i),
         .raw_o      (raw_hit[k]),
         .waw_o      (waw_hit[k])
      );
   end

   // An ALU result lands one cycle after issue, i.e. alongside the mul now in stage S-2.
   always_comb begin
      wb_collision = dec_alu_valid_i & dec_we_i
                   & sb_q[MUL_STAGES-2].valid & sb_q[MUL_STAGES-2].we;
      hazard       = (|raw_hit) | (|waw_hit) | wb_collision;
   end

   always_comb begin
      stall_o     = 1'b0;
      mul_issue_o = 1'b0;
      alu_issue_o = 1'b0;
      if (!rst_i) begin
         stall_o     = (dec_mul_valid_i | dec_alu_valid_i) & hazard & ~flush_i;
         mul_issue_o = dec_mul_valid_i & ~hazard & ~flush_i;
         alu_issue_o = dec_alu_valid_i & ~hazard & ~flush_i;
      end
   end

   // The scoreboard always shifts; a stall or flush simply inserts a bubble.
   always_comb begin
      sb_d[0].valid = mul_issue_o;
      sb_d[0].we    = dec_we_i;
      sb_d[0].rd    = dec_rd_i;
      for (int k = 1; k < MUL_STAGES; k++) begin
         sb_d[k] = sb_q[k-1];
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
         cnt_d = cnt_d + CntW'(sb_d[k].valid);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      for (int k = 0; k < MUL_STAGES; k++) begin
         mul_stage_valid_o[k] = sb_q[k].valid;
      end
      mul_wb_valid_o = sb_q[MUL_STAGES-1].valid & sb_q[MUL_STAGES-1].we;
      mul_wb_addr_o  = sb_q[MUL_STAGES-1].rd;
      inflight_cnt_o = cnt_q;
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed scenarios plus random traffic,
// checked against a timestamp-based model of in-flight multiplies.
module tb_mul_issue_ctrl;

   localparam int S  = 5;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          dec_mul_valid_i;
   logic          dec_alu_valid_i;
   logic [AW-1:0] dec_rd_i;
   logic          dec_we_i;
   logic [AW-1:0] dec_rs1_i;
   logic [AW-1:0] dec_rs2_i;
   logic          dec_rs1_used_i;
   logic          dec_rs2_used_i;
   logic          flush_i;
   logic          stall_o;
   logic          mul_issue_o;
   logic          alu_issue_o;
   logic [S-1:0]  mul_stage_valid_o;
   logic          mul_wb_valid_o;
   logic [AW-1:0] mul_wb_addr_o;
   logic [2:0]    inflight_cnt_o;

   always #5 clk = ~clk;

   mul_issue_ctrl #(
      .MUL_STAGES (S),
      .REG_ADDR_W (AW)
   ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .dec_mul_valid_i   (dec_mul_valid_i),
      .dec_alu_valid_i   (dec_alu_valid_i),
      .dec_rd_i          (dec_rd_i),
      .dec_we_i          (dec_we_i),
      .dec_rs1_i         (dec_rs1_i),
      .dec_rs2_i         (dec_rs2_i),
      .dec_rs1_used_i    (dec_rs1_used_i),
      .dec_rs2_used_i    (dec_rs2_used_i),
      .flush_i           (flush_i),
      .stall_o           (stall_o),
      .mul_issue_o       (mul_issue_o),
      .alu_issue_o       (alu_issue_o),
      .mul_stage_valid_o (mul_stage_valid_o),
      .mul_wb_valid_o    (mul_wb_valid_o),
      .mul_wb_addr_o     (mul_wb_addr_o),
      .inflight_cnt_o    (inflight_cnt_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Model: each issued multiply is remembered with its issue cycle; its stage is its age.
   typedef struct {
      int unsigned   issue;
      bit            we;
      logic [AW-1:0] rd;
   } rec_t;

   rec_t        inflight[$];
   int unsigned now = 0;

   task automatic eval_model(output bit e_stall, output bit e_mul, output bit e_alu,
                             output logic [S-1:0] e_sv, output bit e_wbv,
                             output bit e_last, output logic [AW-1:0] e_wba,
                             output int e_cnt);
      bit haz;
      haz    = 0;
      e_sv   = '0;
      e_wbv  = 0;
      e_last = 0;
      e_wba  = '0;
      e_cnt  = 0;
      foreach (inflight[i]) begin
         int age;
         age = int'(now - inflight[i].issue);
         if (age >= 1 && age <= S) begin
            e_sv[age-1] = 1'b1;
            e_cnt++;
         end
         if (age >= 1 && age <= S - 1 && inflight[i].we && inflight[i].rd != 0) begin
            if (dec_rs1_used_i && dec_rs1_i == inflight[i].rd) haz = 1;
            if (dec_rs2_used_i && dec_rs2_i == inflight[i].rd) haz = 1;
            if (dec_we_i && dec_rd_i != 0 && dec_rd_i == inflight[i].rd) haz = 1;
         end
         if (age == S - 1 && inflight[i].we && dec_alu_valid_i && dec_we_i) haz = 1;
         if (age == S) begin
            e_last = 1;
            e_wbv  = inflight[i].we;
            e_wba  = inflight[i].rd;
         end
      end
      e_stall = !rst_i && (dec_mul_valid_i || dec_alu_valid_i) && haz && !flush_i;
      e_mul   = !rst_i && dec_mul_valid_i && !haz && !flush_i;
      e_alu   = !rst_i && dec_alu_valid_i && !haz && !flush_i;
   endtask

   // One cycle: drive at negedge, check #1 later, advance model at posedge.
   task automatic step(input bit rst, input bit mul, input bit alu, input bit flush,
                       input logic [AW-1:0] rd, input bit we,
                       input logic [AW-1:0] rs1, input bit u1,
                       input logic [AW-1:0] rs2, input bit u2,
                       output bit st, output bit ai);
      bit            e_stall, e_mul, e_alu, e_wbv, e_last;
      logic [S-1:0]  e_sv;
      logic [AW-1:0] e_wba;
      int            e_cnt;
      @(negedge clk);
      rst_i           = rst;
      dec_mul_valid_i = mul;
      dec_alu_valid_i = alu;
      flush_i         = flush;
      dec_rd_i        = rd;
      dec_we_i        = we;
      dec_rs1_i       = rs1;
      dec_rs1_used_i  = u1;
      dec_rs2_i       = rs2;
      dec_rs2_used_i  = u2;
      #1;
      eval_model(e_stall, e_mul, e_alu, e_sv, e_wbv, e_last, e_wba, e_cnt);
      check_eq("stall", 32'(stall_o), 32'(e_stall));
      check_eq("mul_issue", 32'(mul_issue_o), 32'(e_mul));
      check_eq("alu_issue", 32'(alu_issue_o), 32'(e_alu));
      check_eq("stage_valid", 32'(mul_stage_valid_o), 32'(e_sv));
      check_eq("wb_valid", 32'(mul_wb_valid_o), 32'(e_wbv));
      if (e_last) check_eq("wb_addr", 32'(mul_wb_addr_o), 32'(e_wba));
      check_eq("inflight_cnt", 32'(inflight_cnt_o), 32'(e_cnt));
      st = stall_o;
      ai = alu_issue_o;
      @(posedge clk);
      if (rst) inflight.delete();
      else if (e_mul) inflight.push_back('{issue: now, we: we, rd: rd});
      now++;
      while (inflight.size() > 0 && int'(now - inflight[0].issue) > S) void'(inflight.pop_front());
   endtask

   task automatic idle(input int n);
      bit st, ai;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, ai);
   endtask

   initial begin
      bit st, ai;
      int cnt, peak, pos;

      // Reset held 2 cycles with a mul waiting; first free cycle issues it.
      step(1, 1, 0, 0, 5'd1, 1, 0, 0, 0, 0, st, ai);
      step(1, 1, 0, 0, 5'd1, 1, 0, 0, 0, 0, st, ai);
      check_eq("rst_wb_addr", 32'(mul_wb_addr_o), 32'd0);
      step(0, 1, 0, 0, 5'd1, 1, 0, 0, 0, 0, st, ai);
      #1;
      check_eq("first_issue_stage", 32'(mul_stage_valid_o), 32'b00001);
      idle(S + 1);

      // Independent back-to-back muls.
      peak = 0;
      for (int r = 3; r <= 5; r++) step(0, 1, 0, 0, AW'(r), 1, 0, 0, 0, 0, st, ai);
      for (int i = 0; i < S + 2; i++) begin
         if (32'(inflight_cnt_o) > peak) peak = 32'(inflight_cnt_o);
         idle(1);
      end
      check_eq("cnt_peak", 32'(peak), 32'd3);

      // RAW: ALU reading rs1=7 behind mul rd=7 stalls S-1 cycles.
      step(0, 1, 0, 0, 5'd7, 1, 0, 0, 0, 0, st, ai);
      cnt = 0;
      pos = 0;
      for (int i = 1; i <= 8 && pos == 0; i++) begin
         step(0, 0, 1, 0, 5'd8, 1, 5'd7, 1, 0, 0, st, ai);
         if (st) cnt++;
         if (ai) pos = i;
      end
      check_eq("raw_stall_cycles", 32'(cnt), 32'(S - 1));
      check_eq("raw_issue_cycle", 32'(pos), 32'(S));
      idle(S);

      // x0 destination and unused rs2 never stall.
      step(0, 1, 0, 0, 5'd0, 1, 0, 0, 0, 0, st, ai);
      step(0, 0, 1, 0, 5'd2, 1, 5'd0, 1, 0, 0, st, ai);
      check_eq("x0_no_stall", 32'(st), 32'd0);
      step(0, 1, 0, 0, 5'd7, 1, 0, 0, 0, 0, st, ai);
      step(0, 0, 1, 0, 5'd2, 1, 0, 0, 5'd7, 0, st, ai);
      check_eq("unused_rs2_no_stall", 32'(st), 32'd0);
      idle(S);

      // Writeback collision with an unrelated ALU at t+4, with and without we.
      for (int w = 1; w >= 0; w--) begin
         step(0, 1, 0, 0, 5'd9, 1, 0, 0, 0, 0, st, ai);
         idle(S - 2);
         step(0, 0, 1, 0, 5'd10, bit'(w), 5'd11, 1, 0, 0, st, ai);
         check_eq("wb_col_stall", 32'(st), 32'(w));
         if (st) begin
            step(0, 0, 1, 0, 5'd10, bit'(w), 5'd11, 1, 0, 0, st, ai);
            check_eq("wb_col_issue_next", 32'(ai), 32'd1);
         end
         idle(S);
      end

      // Flush during RAW stall, then reset discards the in-flight mul.
      step(0, 1, 0, 0, 5'd7, 1, 0, 0, 0, 0, st, ai);
      step(0, 0, 1, 0, 5'd8, 1, 5'd7, 1, 0, 0, st, ai);
      step(0, 0, 1, 1, 5'd8, 1, 5'd7, 1, 0, 0, st, ai);
      check_eq("flush_no_stall", 32'(st), 32'd0);
      step(1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, st, ai);
      idle(S);
      check_eq("post_rst_no_wb", 32'(mul_wb_valid_o), 32'd0);

      // Random traffic; a stalled instruction is held until it issues or is flushed.
      begin
         bit            mul, alu, fl, rs, we, u1, u2;
         logic [AW-1:0] rd, rs1, rs2;
         st = 0;
         mul = 0; alu = 0; we = 0; u1 = 0; u2 = 0;
         rd = '0; rs1 = '0; rs2 = '0;
         for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 199) == 0);
            if (!st) begin
               case ($urandom_range(0, 3))
                  0:       begin mul = 0; alu = 0; end
                  1, 2:    begin mul = 1; alu = 0; end
                  default: begin mul = 0; alu = 1; end
               endcase
               rd  = AW'($urandom_range(0, 7));
               rs1 = AW'($urandom_range(0, 7));
               rs2 = AW'($urandom_range(0, 7));
               we  = ($urandom_range(0, 4) != 0);
               u1  = $urandom_range(0, 1);
               u2  = $urandom_range(0, 1);
            end
            step(rs, mul, alu, fl, rd, we, rs1, u1, rs2, u2, st, ai);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
